// File: rtl/double_width_packer.sv
// Packs a stream of WIDTH-bit words into 2*WIDTH-bit pairs with valid/ready on both
// sides, a flush that emits a zero-padded partial pair, and a wrapping pair counter.
module double_width_packer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [2*WIDTH-1:0]     out_data,
    output logic                   out_partial,
    input  logic                   out_ready,
    output logic [CNT_WIDTH-1:0]   pair_count
);

    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 partial_q, partial_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 in_xfer, out_xfer;

    function automatic logic [DW-1:0] first_half(input logic [WIDTH-1:0] w);
        first_half = LSB_FIRST ? {{WIDTH{1'b0}}, w} : {w, {WIDTH{1'b0}}};
    endfunction

    function automatic logic [DW-1:0] second_half(input logic [WIDTH-1:0] w);
        second_half = LSB_FIRST ? {w, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, w};
    endfunction

    // ready_q keeps in_ready low during reset and for the edge that ends it.
    always_comb begin
        in_ready = ready_q & ((state_q != FULL) | out_ready);
        in_xfer  = in_valid & in_ready;
        out_xfer = valid_q & out_ready;
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        partial_d = partial_q;
        count_d   = count_q;
        ready_d   = 1'b1;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    data_d  = first_half(in_data);
                    state_d = HALF;
                end
            end
            HALF: begin
                if (in_xfer) begin
                    data_d    = data_q | second_half(in_data);
                    valid_d   = 1'b1;
                    partial_d = 1'b0;
                    state_d   = FULL;
                end else if (flush) begin
                    valid_d   = 1'b1;
                    partial_d = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    count_d   = count_q + 1'b1;
                    valid_d   = 1'b0;
                    partial_d = 1'b0;
                    // in_xfer here implies out_xfer: drain and refill in one cycle
                    if (in_xfer) begin
                        data_d  = first_half(in_data);
                        state_d = HALF;
                    end else begin
                        data_d  = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d   = EMPTY;
                data_d    = '0;
                valid_d   = 1'b0;
                partial_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            count_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        out_valid   = valid_q;
        out_data    = data_q;
        out_partial = partial_q;
        pair_count  = count_q;
    end

endmodule

// File: tb/tb_double_width_packer.sv
// Scoreboard bench: stimulus predicts pairs from the accepted word stream, a monitor
// compares both packing orders against the queue whenever a pair is presented.
module tb_double_width_packer;

    logic        clk, reset, in_valid, flush, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_partial;
    logic [15:0] out_data;
    logic [7:0]  pair_count;
    logic        m_in_ready, m_out_valid, m_out_partial;
    logic [15:0] m_out_data;
    logic [7:0]  m_pair_count;

    double_width_packer #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_WIDTH(8)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_partial(out_partial), .out_ready(out_ready), .pair_count(pair_count));

    double_width_packer #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_WIDTH(8)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_in_ready), .flush(flush), .out_valid(m_out_valid), .out_data(m_out_data),
        .out_partial(m_out_partial), .out_ready(out_ready), .pair_count(m_pair_count));

    typedef struct {
        logic [15:0] lsb;
        logic [15:0] msb;
        logic        partial;
    } pair_t;

    pair_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    pops  = 0;
    bit    m_full = 0;
    bit    m_has  = 0;
    logic [7:0] m_first;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pair(input logic [7:0] w1, input logic [7:0] w2, input bit part);
        pair_t p;
        p.lsb = {w2, w1};
        p.msb = {w1, w2};
        p.partial = part;
        sb.push_back(p);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit r);
        bit exp_ready, in_x, out_x;
        @(negedge clk);
        in_valid = v; in_data = d; flush = f; out_ready = r;
        #1;
        exp_ready = !m_full || r;
        check("in_ready", in_ready, exp_ready);
        check("in_ready_msb", m_in_ready, exp_ready);
        check("out_valid", out_valid, m_full);
        check("out_valid_msb", m_out_valid, m_full);
        in_x  = v && exp_ready;
        out_x = m_full && r;
        if (out_x) m_full = 0;
        if (in_x) begin
            if (m_has) begin
                push_pair(m_first, d, 0);
                m_has = 0;
                m_full = 1;
            end else begin
                m_first = d;
                m_has = 1;
            end
        end else if (f && !v && m_has) begin
            push_pair(m_first, 8'h00, 1);
            m_has = 0;
            m_full = 1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_partial", out_partial, 0);
        check("rst_pair_count", pair_count, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data_msb", m_out_data, 0);
    endtask

    // Monitor: compares the presented pair every cycle (covers hold under backpressure)
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pair", out_data, 16'hxxxx);
                end else begin
                    check("out_data", out_data, sb[0].lsb);
                    check("out_data_msb", m_out_data, sb[0].msb);
                    check("out_partial", out_partial, sb[0].partial);
                    if (out_ready) begin
                        check("pair_count", pair_count, pops % 256);
                        check("pair_count_msb", m_pair_count, pops % 256);
                        pops++;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
        reset = 1;
        #1 reset = 0;
        #1 check_reset_outputs();
        @(negedge clk); @(negedge clk);
        #3 reset = 1;

        // basic pair and count
        cycle(1, 8'hA5, 0, 1);
        cycle(1, 8'h3C, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        check("count_after_first", pair_count, 1);

        // flush partial, then flush in EMPTY does nothing
        cycle(1, 8'h11, 0, 1);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // backpressure, then drain-and-refill with 0x77
        cycle(1, 8'h21, 0, 0);
        cycle(1, 8'h43, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
        cycle(1, 8'h77, 0, 1);
        cycle(1, 8'h88, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // continuous stream across counter wrap
        for (int i = 0; i < 2 * 256 + 2; i++) cycle(1, 8'($urandom), 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // async reset while holding a half pair
        cycle(1, 8'h55, 0, 1);
        cycle(0, 8'h00, 0, 1);
        @(negedge clk);
        in_valid = 0; flush = 0;
        #3 reset = 0;
        #1 check_reset_outputs();
        sb.delete();
        m_full = 0; m_has = 0; pops = 0;
        @(negedge clk); @(negedge clk);
        #3 reset = 1;
        cycle(1, 8'h12, 0, 1);
        cycle(1, 8'h34, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        check("count_after_reset", pair_count, 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
